// File: rtl/audio_playback_buffer.sv
// audio_playback_buffer: stereo PCM FIFO + stage register feeding the codec, with ADC capture and underrun tracking
module audio_playback_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter logic [WIDTH-1:0] SILENCE = '0
) (
  input  logic                     i_clock_50,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH-1:0]         i_in_left,
  input  logic [WIDTH-1:0]         i_in_right,
  input  logic                     i_advance,
  output logic [WIDTH-1:0]         o_dac_left,
  output logic [WIDTH-1:0]         o_dac_right,
  input  logic [WIDTH-1:0]         i_adc_left,
  input  logic [WIDTH-1:0]         i_adc_right,
  output logic [WIDTH-1:0]         o_cap_left,
  output logic [WIDTH-1:0]         o_cap_right,
  output logic                     o_cap_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_underrun,
  output logic [15:0]              o_underrun_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [LW-1:0]      r_level;
  logic [WIDTH-1:0]   r_stage_l, r_stage_r;
  logic               r_stage_valid;
  logic [WIDTH-1:0]   r_cap_l, r_cap_r;
  logic               r_cap_valid, r_underrun;
  logic [15:0]        r_ucnt;
  logic               w_push, w_take, w_pop;

  // ready depends only on registered occupancy, never on advance
  assign o_in_ready = r_level != LW'(DEPTH);
  assign w_push     = i_in_valid & o_in_ready;
  assign w_take     = i_advance & i_enable;
  // pop on a live advance, or prefetch into an empty stage when no advance is pending
  assign w_pop      = (r_level != '0) & (w_take | (!r_stage_valid & !i_advance));

  assign o_dac_left       = (i_enable & r_stage_valid) ? r_stage_l : SILENCE;
  assign o_dac_right      = (i_enable & r_stage_valid) ? r_stage_r : SILENCE;
  assign o_cap_left       = r_cap_l;
  assign o_cap_right      = r_cap_r;
  assign o_cap_valid      = r_cap_valid;
  assign o_level          = r_level;
  assign o_underrun       = r_underrun;
  assign o_underrun_count = r_ucnt;

  // sample storage; stale contents are harmless because pointers reset
  always_ff @(posedge i_clock_50)
    if (w_push) r_mem[r_wr] <= {i_in_left, i_in_right};

  // FIFO pointers and occupancy
  always_ff @(posedge i_clock_50)
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end

  // stage register: loaded from head on pop, emptied by an advance that finds the FIFO empty
  always_ff @(posedge i_clock_50)
    if (i_reset) begin
      r_stage_l     <= SILENCE;
      r_stage_r     <= SILENCE;
      r_stage_valid <= 1'b0;
    end else if (w_pop) begin
      {r_stage_l, r_stage_r} <= r_mem[r_rd];
      r_stage_valid          <= 1'b1;
    end else if (w_take) begin
      r_stage_valid <= 1'b0;
    end

  // ADC capture on every advance, underrun pulse and saturating count on live advances
  always_ff @(posedge i_clock_50)
    if (i_reset) begin
      r_cap_l     <= '0;
      r_cap_r     <= '0;
      r_cap_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_ucnt      <= '0;
    end else begin
      if (i_advance) begin
        r_cap_l <= i_adc_left;
        r_cap_r <= i_adc_right;
      end
      r_cap_valid <= i_advance;
      r_underrun  <= w_take & !r_stage_valid;
      if (w_take & !r_stage_valid & (r_ucnt != 16'hFFFF)) r_ucnt <= r_ucnt + 16'd1;
    end
endmodule

// File: tb/tb_audio_playback_buffer.sv
// tb_audio_playback_buffer: vector table, corner sequences and randomized queue-model checks
module tb_audio_playback_buffer;
  localparam int D = 16;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, vld, adv;
  logic [W-1:0] il, ir, al, ar;
  logic rdy, capv, und;
  logic [W-1:0] dl, dr, cl, cr;
  logic [4:0] lvl;
  logic [15:0] ucnt;

  audio_playback_buffer #(.DEPTH(D), .WIDTH(W)) dut (
    .i_clock_50(clk), .i_reset(rst), .i_enable(en), .i_in_valid(vld), .o_in_ready(rdy),
    .i_in_left(il), .i_in_right(ir), .i_advance(adv), .o_dac_left(dl), .o_dac_right(dr),
    .i_adc_left(al), .i_adc_right(ar), .o_cap_left(cl), .o_cap_right(cr), .o_cap_valid(capv),
    .o_level(lvl), .o_underrun(und), .o_underrun_count(ucnt)
  );

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] q[$];
  bit m_sv, m_cv, m_un;
  logic [W-1:0] m_sl, m_sr, m_cl, m_cr;
  int m_cnt;

  typedef struct {
    bit r, e, v, a;
    logic [W-1:0] l, c;
    bit x_rdy;
    int x_lvl;
    logic [W-1:0] x_dac;
    bit x_und;
    int x_cnt;
    bit x_capv;
    logic [W-1:0] x_cap;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, ex);
    end
  endtask

  task automatic drive(input bit r, e, v, a, input logic [W-1:0] l, c);
    rst = r; en = e; vld = v; adv = a;
    il = l; ir = l + 24'h100000;
    al = c; ar = c + 24'd1;
  endtask

  task automatic check_model();
    logic [W-1:0] xl, xr;
    xl = (en && m_sv) ? m_sl : '0;
    xr = (en && m_sv) ? m_sr : '0;
    chk("ready", 32'(rdy), 32'(q.size() != D));
    chk("level", 32'(lvl), 32'(q.size()));
    chk("dac_left", 32'(dl), 32'(xl));
    chk("dac_right", 32'(dr), 32'(xr));
    chk("underrun", 32'(und), 32'(m_un));
    chk("underrun_count", 32'(ucnt), 32'(m_cnt));
    chk("cap_valid", 32'(capv), 32'(m_cv));
    chk("cap_left", 32'(cl), 32'(m_cl));
    chk("cap_right", 32'(cr), 32'(m_cr));
  endtask

  // advance one clock and update the queue model with the inputs applied in that cycle
  task automatic step();
    bit push;
    logic [2*W-1:0] h;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_sv = 0; m_cv = 0; m_un = 0; m_cnt = 0;
      m_cl = '0; m_cr = '0; m_sl = '0; m_sr = '0;
    end else begin
      push = vld && (q.size() < D);
      m_cv = adv;
      if (adv) begin m_cl = al; m_cr = ar; end
      m_un = adv && en && !m_sv;
      if (m_un && m_cnt < 65535) m_cnt++;
      if (adv && en) begin
        if (q.size() > 0) begin h = q.pop_front(); {m_sl, m_sr} = h; m_sv = 1; end
        else m_sv = 0;
      end else if (!adv && !m_sv && q.size() > 0) begin
        h = q.pop_front(); {m_sl, m_sr} = h; m_sv = 1;
      end
      if (push) q.push_back({il, ir});
    end
    @(negedge clk);
  endtask

  task automatic peek(input bit r, e, v, a, input logic [W-1:0] l, c);
    drive(r, e, v, a, l, c);
    #1;
    check_model();
  endtask

  task automatic run(input bit r, e, v, a, input logic [W-1:0] l, c);
    peek(r, e, v, a, l, c);
    step();
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 0, '0, '0);
    step();
    step();
  endtask

  initial begin
    int gap;
    bit a;
    //          r e v a  l        c        rdy lvl dac      und cnt capv cap
    tbl[0]  = '{0,1,1,0, 24'h111, 24'h0,   1,  0,  24'h0,   0,  0,  0,   24'h0};
    tbl[1]  = '{0,1,1,0, 24'h112, 24'h0,   1,  1,  24'h0,   0,  0,  0,   24'h0};
    tbl[2]  = '{0,1,1,0, 24'h113, 24'h0,   1,  1,  24'h111, 0,  0,  0,   24'h0};
    tbl[3]  = '{0,1,0,0, 24'h0,   24'h0,   1,  2,  24'h111, 0,  0,  0,   24'h0};
    tbl[4]  = '{0,1,0,1, 24'h0,   24'h0AA, 1,  2,  24'h111, 0,  0,  0,   24'h0};
    tbl[5]  = '{0,1,0,0, 24'h0,   24'h0,   1,  1,  24'h112, 0,  0,  1,   24'h0AA};
    tbl[6]  = '{0,0,0,0, 24'h0,   24'h0,   1,  1,  24'h0,   0,  0,  0,   24'h0AA};
    tbl[7]  = '{0,0,0,1, 24'h0,   24'h0CC, 1,  1,  24'h0,   0,  0,  0,   24'h0AA};
    tbl[8]  = '{0,1,0,1, 24'h0,   24'h0DD, 1,  1,  24'h112, 0,  0,  1,   24'h0CC};
    tbl[9]  = '{0,1,0,0, 24'h0,   24'h0,   1,  0,  24'h113, 0,  0,  1,   24'h0DD};
    tbl[10] = '{0,1,0,1, 24'h0,   24'h0EE, 1,  0,  24'h113, 0,  0,  0,   24'h0DD};
    tbl[11] = '{0,1,0,0, 24'h0,   24'h0,   1,  0,  24'h0,   0,  0,  1,   24'h0EE};
    tbl[12] = '{0,1,0,1, 24'h0,   24'h0,   1,  0,  24'h0,   0,  0,  0,   24'h0EE};
    tbl[13] = '{0,1,0,0, 24'h0,   24'h0,   1,  0,  24'h0,   1,  1,  1,   24'h0};
    tbl[14] = '{0,1,0,0, 24'h0,   24'h0,   1,  0,  24'h0,   0,  1,  0,   24'h0};

    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].c);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].x_rdy));
      chk($sformatf("tbl%0d_level", i), 32'(lvl), 32'(tbl[i].x_lvl));
      chk($sformatf("tbl%0d_dac_l", i), 32'(dl), 32'(tbl[i].x_dac));
      chk($sformatf("tbl%0d_dac_r", i), 32'(dr), 32'(tbl[i].x_dac == '0 ? '0 : tbl[i].x_dac + 24'h100000));
      chk($sformatf("tbl%0d_underrun", i), 32'(und), 32'(tbl[i].x_und));
      chk($sformatf("tbl%0d_ucnt", i), 32'(ucnt), 32'(tbl[i].x_cnt));
      chk($sformatf("tbl%0d_capv", i), 32'(capv), 32'(tbl[i].x_capv));
      chk($sformatf("tbl%0d_cap_l", i), 32'(cl), 32'(tbl[i].x_cap));
      step();
    end

    // fill: DEPTH+1 accepted (FIFO plus stage), extra pushes dropped, then drain in order
    do_reset();
    for (int i = 0; i < D + 3; i++) run(0, 1, 1, 0, 24'h500 + 24'(i), '0);
    drive(0, 1, 1, 0, 24'h5FF, '0);
    #1;
    chk("full_level", 32'(lvl), 32'(D));
    chk("full_ready", 32'(rdy), 32'd0);
    chk("full_dac_head", 32'(dl), 32'h500);
    step();
    for (int i = 0; i < D + 3; i++) begin
      run(0, 1, 0, 1, '0, 24'(i));
      run(0, 1, 0, 0, '0, '0);
      run(0, 1, 0, 0, '0, '0);
    end

    // empty buffer: three underruns, then a push reaches the DAC two cycles later
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run(0, 1, 0, 1, '0, 24'h70 + 24'(i));
      run(0, 1, 0, 0, '0, '0);
      run(0, 1, 0, 0, '0, '0);
    end
    peek(0, 1, 1, 0, 24'h777, '0);
    chk("und_count3", 32'(ucnt), 32'd3);
    chk("und_dac_silent", 32'(dl), 32'd0);
    step();
    run(0, 1, 0, 0, '0, '0);
    peek(0, 1, 0, 0, '0, '0);
    chk("latency_dac", 32'(dl), 32'h777);
    step();

    // simultaneous push and advance with level 1
    do_reset();
    run(0, 1, 1, 0, 24'hA01, '0);
    run(0, 1, 1, 0, 24'hA02, '0);
    run(0, 1, 0, 0, '0, '0);
    run(0, 1, 1, 1, 24'hA03, 24'h1);
    peek(0, 1, 0, 0, '0, '0);
    chk("pushpop_level", 32'(lvl), 32'd1);
    chk("pushpop_dac", 32'(dl), 32'hA02);
    step();

    // muted advances with level 4
    do_reset();
    for (int i = 0; i < 5; i++) run(0, 0, 1, 0, 24'hB00 + 24'(i), '0);
    run(0, 0, 0, 0, '0, '0);
    run(0, 0, 0, 1, '0, 24'hC1);
    run(0, 0, 0, 0, '0, '0);
    run(0, 0, 0, 1, '0, 24'hC2);
    peek(0, 0, 0, 0, '0, '0);
    chk("mute_level", 32'(lvl), 32'd4);
    chk("mute_cap", 32'(cl), 32'hC2);
    chk("mute_ucnt", 32'(ucnt), 32'd0);
    step();

    // reset lands on a push+advance cycle with level 5
    do_reset();
    for (int i = 0; i < 6; i++) run(0, 1, 1, 0, 24'hD00 + 24'(i), '0);
    run(0, 1, 0, 1, '0, '0);
    run(0, 1, 0, 0, '0, '0);
    run(0, 1, 0, 0, '0, '0);
    run(0, 1, 1, 0, 24'hD10, '0);
    peek(0, 1, 0, 0, '0, '0);
    chk("pre_reset_level", 32'(lvl), 32'd5);
    step();
    run(1, 1, 1, 1, 24'hDEE, 24'h55);
    peek(0, 1, 0, 0, '0, '0);
    chk("rst_level", 32'(lvl), 32'd0);
    chk("rst_dac", 32'(dl), 32'd0);
    chk("rst_capv", 32'(capv), 32'd0);
    step();

    // randomized traffic against the queue model
    gap = 2;
    for (int i = 0; i < 4000; i++) begin
      a = (gap == 0);
      if (a) gap = $urandom_range(0, 6); else gap--;
      run($urandom_range(0, 599) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 99) < ((i % 1000) < 500 ? 45 : 15), a,
          W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
